rng_share_arbiter: RTL and testbench
====================================

Name: rng_share_arbiter

Overview:
- Shares the single 20-bit LFSR random word source among up to NUM_REQ game-logic requesters: obstacle lane picker, coin spawner, power-up spawner and track-turn selector.
- Each published random word goes to at most one requester, so two spawners never act on the same value.
- Requesters are served round-robin.
- Sits between random_generator and the spawn/track FSMs in the game-logic clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RND_W, 20, width of the incoming random word.
- OUT_W, 8, width of the folded random value delivered to requesters (OUT_W <= RND_W/2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rnd_in  input  RND_W  current random word from the generator.
- rnd_valid  input  1  one-cycle strobe: rnd_in holds a newly published word.
- req  input  NUM_REQ  level request per requester; held until granted.
- grant  output  NUM_REQ  one-hot, one-cycle pulse naming the served requester.
- rnd_out  output  OUT_W  folded random value; valid only while rnd_out_valid = 1.
- rnd_out_valid  output  1  one-cycle pulse coincident with grant.
- busy  output  1  high while an unconsumed word is held (state HOLD or GRANT).

Behaviour:
- Reset (async): state = EMPTY; grant = 0; rnd_out = 0; rnd_out_valid = 0; busy = 0; word register = 0; RR pointer = 0 (requester 0 has top priority).
- FSM states: EMPTY (no fresh word), HOLD (fresh word latched, waiting for a request), GRANT (delivery cycle).
- EMPTY:
  - rnd_valid = 1 -> latch rnd_in, go to HOLD.
  - Requests wait in this state.
- HOLD:
  - req != 0 -> pick the first set bit at or above the RR pointer, wrapping modulo NUM_REQ; go to GRANT.
  - rnd_valid while in HOLD -> overwrite the word register with the newer word (overrun); stay in HOLD.
- GRANT (one cycle):
  - grant = one-hot of the winner; rnd_out_valid = 1.
  - rnd_out = word[OUT_W-1:0] XOR word[RND_W-1 -: OUT_W].
  - RR pointer = winner + 1, wrapping modulo NUM_REQ.
  - Next state = HOLD if rnd_valid is high in this cycle (new word latched), else EMPTY.
- All outputs are registered. Latency:
  - Request pending in HOLD at edge N -> grant high in cycle N+1.
  - Request pending in EMPTY, rnd_valid at cycle N -> HOLD at N+1, grant at N+2.
- Arbitration uses req sampled in the HOLD cycle only. A requester that drops req before that cycle is not served.
- A requester must drop req in the cycle after its grant. If req is still high at the next arbitration, it counts as a new request.
- Only one grant per word, ever. With every req bit high, grants rotate 0,1,2,3,0,...
- Bits of req at index >= NUM_REQ do not exist. If all req = 0, the FSM stays in HOLD indefinitely, refreshing the word on each rnd_valid.
- rnd_valid arriving in the same cycle as a GRANT is never lost.

Optional Feature:
- Macro: RNG_OVERRUN_CNT_EN.
- When defined:
  - Adds output overrun_cnt [7:0], a saturating count of words discarded unconsumed.
  - Increments on rnd_valid in HOLD; saturates at 255.
  - Resets to 0; cleared by the async reset only.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package rng_pkg:
  - localparams RND_W_DEF = 20 and OUT_W_DEF = 8.
  - FSM state encoding: EMPTY = 2'd0, HOLD = 2'd1, GRANT = 2'd2.
  - The fold function (low half XOR high half).
- One sub-module: rr_picker. It is combinational: inputs req and pointer, outputs a one-hot winner and its index. It is reused by the spawn scheduler later.

Test Plan:
- Reset mid-GRANT:
  - Stimulus: assert reset while grant = 4'b0010.
  - Response: grant, rnd_out_valid and busy are 0 immediately (async); after release, req = 4'b0010 with no rnd_valid produces no grant.
- Basic delivery:
  - Stimulus: rnd_valid with rnd_in = 20'hA5C3F, req = 4'b0001.
  - Response: grant = 4'b0001 two cycles after rnd_valid; rnd_out = 8'h3F ^ 8'hA5 = 8'h9A; rnd_out_valid pulses once.
- Round-robin:
  - Stimulus: req = 4'b1111 held; rnd_valid every 21 cycles for 5 words.
  - Response: grants 0001, 0010, 0100, 1000, 0001; one grant per word, never two per word.
- No request:
  - Stimulus: req = 0; rnd_valid with 20'h00001, then 20'h00002.
  - Response: no grant. Then req = 4'b0100 yields rnd_out = 8'h02 (latest word); overrun_cnt = 1 when RNG_OVERRUN_CNT_EN is defined.
- Simultaneous new word and GRANT:
  - Stimulus: rnd_valid coincides with GRANT to requester 1; req[2] is pending.
  - Response: the next state is HOLD and requester 2 is granted the new word on the following cycle pair.
- Overrun saturation (RNG_OVERRUN_CNT_EN defined):
  - Stimulus: 300 rnd_valid strobes with req = 0.
  - Response: overrun_cnt = 255.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared definitions for the random-word sharing logic: default widths,
// FSM state encoding and the fold that narrows a random word.
package rng_pkg;

    localparam int RND_W_DEF = 20;
    localparam int OUT_W_DEF = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        GRANT = 2'd2
    } rng_state_t;

    // XOR the low out_w bits with the top out_w bits of an rnd_w-bit word.
    // Words up to 32 bits and folded values up to 16 bits are supported.
    function automatic logic [15:0] fold(input logic [31:0] word, input int rnd_w, input int out_w);
        logic [15:0] result;
        result = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < out_w) begin
                result[i] = word[i] ^ word[rnd_w - out_w + i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rng_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N. Returns the winner one-hot, its index and a found flag.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] winner_idx,
    output logic          found
);

    logic [N-1:0]  rot;
    logic [PW-1:0] rot_idx [N];

    // rot[k] is the request k positions after the pointer
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [PW:0] sum;
            assign sum         = {1'b0, ptr} + (PW+1)'(gi);
            assign rot_idx[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
            assign rot[gi]     = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner_idx = '0;
        found      = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                winner_idx = rot_idx[k];
                found      = 1'b1;
            end
        end
        winner = found ? (N'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/rng_share_arbiter.sv
// Hands each published random word to at most one requester, round-robin.
// Optional saturating overrun counter when RNG_OVERRUN_CNT_EN is defined.
module rng_share_arbiter
    import rng_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RND_W   = RND_W_DEF,
    parameter int OUT_W   = OUT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RND_W-1:0]   rnd_in,
    input  logic               rnd_valid,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [OUT_W-1:0]   rnd_out,
    output logic               rnd_out_valid,
    output logic               busy
`ifdef RNG_OVERRUN_CNT_EN
    ,
    output logic [7:0]         overrun_cnt
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rng_state_t         state_reg, state_next;
    logic [RND_W-1:0]   word_reg, word_next;
    logic [PW-1:0]      ptr_reg, ptr_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [OUT_W-1:0]   rnd_out_reg, rnd_out_next;
    logic               valid_reg, valid_next;
    logic               busy_reg, busy_next;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [PW-1:0]      pick_idx;
    logic               pick_found;

    rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_picker (
        .req        (req),
        .ptr        (ptr_reg),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= EMPTY;
            word_reg    <= '0;
            ptr_reg     <= '0;
            grant_reg   <= '0;
            rnd_out_reg <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            word_reg    <= word_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            rnd_out_reg <= rnd_out_next;
            valid_reg   <= valid_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        word_next    = word_reg;
        ptr_next     = ptr_reg;
        grant_next   = '0;
        rnd_out_next = rnd_out_reg;
        valid_next   = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (rnd_valid) begin
                    word_next  = rnd_in;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // A word arriving in the arbitration cycle replaces the held one,
                // so the winner always receives the newest word.
                if (rnd_valid) begin
                    word_next = rnd_in;
                end
                if (pick_found) begin
                    state_next   = GRANT;
                    grant_next   = pick_onehot;
                    valid_next   = 1'b1;
                    rnd_out_next = OUT_W'(fold(32'(word_next), RND_W, OUT_W));
                    ptr_next     = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + PW'(1);
                end
            end
            GRANT: begin
                if (rnd_valid) begin
                    word_next  = rnd_in;
                    state_next = HOLD;
                end else begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        busy_next = (state_next != EMPTY);
    end

    assign grant         = grant_reg;
    assign rnd_out       = rnd_out_reg;
    assign rnd_out_valid = valid_reg;
    assign busy          = busy_reg;

`ifdef RNG_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_cnt_reg <= '0;
        end else if (state_reg == HOLD && rnd_valid && ovr_cnt_reg != 8'hFF) begin
            ovr_cnt_reg <= ovr_cnt_reg + 8'd1;
        end
    end

    assign overrun_cnt = ovr_cnt_reg;
`endif

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Directed plus randomized checks of rng_share_arbiter against a
// transaction-level model (pointer, fold arithmetic, overrun count).
module tb_rng_share_arbiter;

    localparam int N  = 4;
    localparam int RW = 20;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [RW-1:0] rnd_in = '0;
    logic          rnd_valid = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  grant;
    logic [OW-1:0] rnd_out;
    logic          rnd_out_valid;
    logic          busy;
`ifdef RNG_OVERRUN_CNT_EN
    logic [7:0]    overrun_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;
    int m_ovr  = 0;

    rng_share_arbiter #(.NUM_REQ(N), .RND_W(RW), .OUT_W(OW)) dut (
        .clk           (clk),
        .reset         (reset),
        .rnd_in        (rnd_in),
        .rnd_valid     (rnd_valid),
        .req           (req),
        .grant         (grant),
        .rnd_out       (rnd_out),
        .rnd_out_valid (rnd_out_valid),
        .busy          (busy)
`ifdef RNG_OVERRUN_CNT_EN
        ,
        .overrun_cnt   (overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_fold(input logic [RW-1:0] w);
        int v;
        v = int'(w);
        return (v % (1 << OW)) ^ (v >> (RW - OW));
    endfunction

    function automatic int m_pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int m_sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From idle: publish a word (optionally overrun by w in HOLD), request with m,
    // check the single grant and return to idle.
    task automatic deliver(input string tag, input logic [RW-1:0] w, input logic [N-1:0] m,
                           input bit overrun_first, input logic [RW-1:0] w0,
                           output logic [OW-1:0] got);
        int win;
        if (overrun_first) begin
            req = '0; rnd_in = w0; rnd_valid = 1'b1;
            tick();
            rnd_in = w;
            tick();
            m_ovr = m_sat(m_ovr + 1);
            rnd_valid = 1'b0;
            check({tag, "_hold_busy"}, 32'(busy), 32'd1);
            check({tag, "_hold_nogrant"}, 32'(grant), 32'd0);
            req = m;
            tick();
        end else begin
            req = m; rnd_in = w; rnd_valid = 1'b1;
            tick();
            rnd_valid = 1'b0;
            check({tag, "_hold_busy"}, 32'(busy), 32'd1);
            check({tag, "_hold_nogrant"}, 32'(grant), 32'd0);
            tick();
        end
        win = m_pick(m);
        check({tag, "_grant"}, 32'(grant), 32'(1 << win));
        check({tag, "_rnd_out"}, 32'(rnd_out), 32'(m_fold(w)));
        check({tag, "_valid"}, 32'(rnd_out_valid), 32'd1);
        got = rnd_out;
        $display("txn %s word=%05h req=%b grant=%b rnd_out=%02h", tag, w, m, grant, rnd_out);
        m_ptr = (win + 1) % N;
        req = '0;
        tick();
        check({tag, "_after_grant"}, 32'(grant), 32'd0);
        check({tag, "_after_valid"}, 32'(rnd_out_valid), 32'd0);
        check({tag, "_after_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [OW-1:0] got;
        logic [N-1:0]  rr_tab [5];
        logic [RW-1:0] w, w2;
        logic [N-1:0]  g;
        logic [OW-1:0] o;
        int            ngr, win;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_valid", 32'(rnd_out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rnd_out", 32'(rnd_out), 32'd0);
`ifdef RNG_OVERRUN_CNT_EN
        check("rst_ovr", 32'(overrun_cnt), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Basic delivery
        deliver("basic", 20'hA5C3F, 4'b0001, 1'b0, '0, got);
        check("basic_const", 32'(got), 32'h9A);

        // Reset in the middle of a grant cycle
        req = 4'b0010; rnd_in = 20'h12345; rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        tick();
        check("rstmid_grant_pre", 32'(grant), 32'b0010);
        reset = 1'b1;
        #1;
        check("rstmid_grant", 32'(grant), 32'd0);
        check("rstmid_valid", 32'(rnd_out_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        $display("txn reset_mid_grant grant=%b busy=%b", grant, busy);
        tick();
        reset = 1'b0;
        m_ptr = 0;
        m_ovr = 0;
        ngr = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (grant != '0) ngr++;
        end
        check("rstmid_no_grant", 32'(ngr), 32'd0);
        req = '0;
        tick();

        // Round-robin with all requests held
        rr_tab[0] = 4'b0001; rr_tab[1] = 4'b0010; rr_tab[2] = 4'b0100;
        rr_tab[3] = 4'b1000; rr_tab[4] = 4'b0001;
        req = 4'b1111;
        for (int wd = 0; wd < 5; wd++) begin
            w = RW'($urandom);
            rnd_in = w; rnd_valid = 1'b1;
            ngr = 0; g = '0; o = '0;
            for (int c = 0; c < 21; c++) begin
                tick();
                rnd_valid = 1'b0;
                if (grant != '0) begin
                    ngr++;
                    g = grant;
                    o = rnd_out;
                end
            end
            win = m_pick(4'b1111);
            check("rr_count", 32'(ngr), 32'd1);
            check("rr_grant", 32'(g), 32'(1 << win));
            check("rr_table", 32'(g), 32'(rr_tab[wd]));
            check("rr_rnd_out", 32'(o), 32'(m_fold(w)));
            $display("txn rr word=%05h grant=%b rnd_out=%02h", w, g, o);
            m_ptr = (win + 1) % N;
        end
        req = '0;
        tick();

        // No request: words refresh, latest one is delivered
        rnd_in = 20'h00001; rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        ngr = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (grant != '0) ngr++;
        end
        rnd_in = 20'h00002; rnd_valid = 1'b1;
        tick();
        m_ovr = m_sat(m_ovr + 1);
        rnd_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (grant != '0) ngr++;
        end
        check("noreq_no_grant", 32'(ngr), 32'd0);
        check("noreq_busy", 32'(busy), 32'd1);
        req = 4'b0100;
        tick();
        check("noreq_grant", 32'(grant), 32'b0100);
        check("noreq_rnd_out", 32'(rnd_out), 32'h02);
`ifdef RNG_OVERRUN_CNT_EN
        check("noreq_ovr", 32'(overrun_cnt), 32'(m_ovr));
`endif
        $display("txn noreq grant=%b rnd_out=%02h", grant, rnd_out);
        m_ptr = 3;
        req = '0;
        tick();

        // New word arriving in the grant cycle
        w = RW'($urandom); w2 = RW'($urandom);
        req = 4'b0110; rnd_in = w; rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        tick();
        win = m_pick(4'b0110);
        check("simul_grant1", 32'(grant), 32'(1 << win));
        check("simul_grant1_idx", 32'(win), 32'd1);
        check("simul_out1", 32'(rnd_out), 32'(m_fold(w)));
        m_ptr = (win + 1) % N;
        rnd_in = w2; rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        req = 4'b0100;
        check("simul_hold_busy", 32'(busy), 32'd1);
        check("simul_hold_nogrant", 32'(grant), 32'd0);
        tick();
        win = m_pick(4'b0100);
        check("simul_grant2", 32'(grant), 32'b0100);
        check("simul_out2", 32'(rnd_out), 32'(m_fold(w2)));
        $display("txn simul words=%05h,%05h grant=%b rnd_out=%02h", w, w2, grant, rnd_out);
        m_ptr = (win + 1) % N;
        req = '0;
        tick();
        check("simul_idle_busy", 32'(busy), 32'd0);

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            deliver("rand", RW'($urandom), N'($urandom_range(1, (1 << N) - 1)),
                    1'($urandom_range(0, 1)), RW'($urandom), got);
        end
`ifdef RNG_OVERRUN_CNT_EN
        check("rand_ovr", 32'(overrun_cnt), 32'(m_ovr));
`endif

        // Long run of unconsumed words
        ngr = 0;
        for (int i = 0; i < 300; i++) begin
            w = RW'($urandom);
            rnd_in = w; rnd_valid = 1'b1;
            tick();
            if (grant != '0) ngr++;
        end
        rnd_valid = 1'b0;
        m_ovr = m_sat(m_ovr + 299);
        check("sat_no_grant", 32'(ngr), 32'd0);
        check("sat_busy", 32'(busy), 32'd1);
`ifdef RNG_OVERRUN_CNT_EN
        check("sat_ovr", 32'(overrun_cnt), 32'(m_ovr));
`endif
        req = 4'b0001;
        tick();
        check("sat_drain_grant", 32'(grant), 32'b0001);
        check("sat_drain_out", 32'(rnd_out), 32'(m_fold(w)));
        $display("txn sat_drain word=%05h grant=%b rnd_out=%02h", w, grant, rnd_out);
        req = '0;
        tick();
        check("sat_idle_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
